// File: rtl/lfsr_checker.sv
// Serial PRBS checker: self-synchronises on LENGTH received bits, then predicts
// each following bit from its own Fibonacci LFSR and reports errors and lock status.
module lfsr_checker #(
  parameter int LENGTH      = 4,
  parameter int COUNT_W     = 16,
  parameter int WINDOW      = 64,
  parameter int LOSS_THRESH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               din,
  input  logic               din_valid,
  input  logic               clr_count,
  output logic               locked,
  output logic               err,
  output logic               lock_lost,
  output logic [COUNT_W-1:0] err_count
);

  localparam bit SUPPORTED = (LENGTH == 2) || (LENGTH == 3) || (LENGTH == 4) ||
                             (LENGTH == 8) || (LENGTH == 16);
  localparam int HW = (LENGTH > 16) ? LENGTH : 16;
  localparam int FW = $clog2(LENGTH + 1);
  localparam int WW = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam int EW = $clog2(LOSS_THRESH + 1);

  typedef enum logic {SEARCH = 1'b0, LOCKED = 1'b1} state_t;

  state_t              state, state_nxt;
  logic [LENGTH-1:0]   h, h_nxt;
  logic [HW-1:0]       hx;
  logic [FW-1:0]       fill_cnt, fill_nxt;
  logic [WW-1:0]       win_cnt, win_cnt_nxt;
  logic [EW-1:0]       win_err, win_err_nxt, win_err_sum;
  logic                fb, mismatch, lose;
  logic                err_nxt, lock_lost_nxt;
  logic [COUNT_W-1:0]  err_count_nxt;

  function automatic logic predict(input logic [HW-1:0] hv);
    case (LENGTH)
      2:       predict = hv[0] ^ hv[1];
      3:       predict = hv[0] ^ hv[2];
      4:       predict = hv[0] ^ hv[3];
      8:       predict = hv[0] ^ hv[2] ^ hv[3] ^ hv[4];
      16:      predict = hv[0] ^ hv[2] ^ hv[3] ^ hv[5];
      default: predict = 1'b0;
    endcase
  endfunction

  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] c);
    sat_inc = (&c) ? c : c + COUNT_W'(1);
  endfunction

  assign hx          = HW'(h);
  assign fb          = predict(hx);
  assign win_err_sum = win_err + EW'(mismatch);
  assign locked      = (state == LOCKED);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= SEARCH;
      h         <= '0;
      fill_cnt  <= '0;
      win_cnt   <= '0;
      win_err   <= '0;
      err       <= 1'b0;
      lock_lost <= 1'b0;
      err_count <= '0;
    end else begin
      state     <= state_nxt;
      h         <= h_nxt;
      fill_cnt  <= fill_nxt;
      win_cnt   <= win_cnt_nxt;
      win_err   <= win_err_nxt;
      err       <= err_nxt;
      lock_lost <= lock_lost_nxt;
      err_count <= err_count_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    h_nxt       = h;
    fill_nxt    = fill_cnt;
    win_cnt_nxt = win_cnt;
    win_err_nxt = win_err;
    mismatch    = 1'b0;
    lose        = 1'b0;
    if (din_valid && SUPPORTED) begin
      case (state)
        SEARCH: begin
          h_nxt = {din, h[LENGTH-1:1]};
          if (fill_cnt == FW'(LENGTH - 1)) begin
            fill_nxt = '0;
            // An all-zero register is the LFSR lock-up state; keep searching.
            if (h_nxt != '0) begin
              state_nxt   = LOCKED;
              win_cnt_nxt = '0;
              win_err_nxt = '0;
            end
          end else begin
            fill_nxt = fill_cnt + FW'(1);
          end
        end
        LOCKED: begin
          // Shift in the prediction so one corrupted bit is counted only once.
          h_nxt    = {fb, h[LENGTH-1:1]};
          mismatch = (din != fb);
          if (mismatch && (win_err_sum == EW'(LOSS_THRESH))) begin
            state_nxt   = SEARCH;
            fill_nxt    = '0;
            win_cnt_nxt = '0;
            win_err_nxt = '0;
            lose        = 1'b1;
          end else if (win_cnt == WW'(WINDOW - 1)) begin
            win_cnt_nxt = '0;
            win_err_nxt = '0;
          end else begin
            win_cnt_nxt = win_cnt + WW'(1);
            win_err_nxt = win_err_sum;
          end
        end
        default: state_nxt = SEARCH;
      endcase
    end
  end

  always_comb begin
    err_nxt       = mismatch;
    lock_lost_nxt = lose;
    err_count_nxt = err_count;
    if (clr_count)
      err_count_nxt = '0;
    else if (mismatch)
      err_count_nxt = sat_inc(err_count);
  end

endmodule

// File: tb/tb_lfsr_checker.sv
// Bench for lfsr_checker: directed phases plus randomised traffic, checked against
// a recurrence-based model of the LENGTH=4 stream (s[n] = s[n-4] ^ s[n-1]).
module tb_lfsr_checker;
  logic        clk = 1'b0;
  logic        rst, din, din_valid, clr_count;
  logic        locked, err, lock_lost;
  logic [15:0] err_count;
  logic        locked_s, err_s, lock_lost_s;
  logic [3:0]  err_count_s;

  always #5 clk = ~clk;

  lfsr_checker #(.LENGTH(4), .COUNT_W(16), .WINDOW(64), .LOSS_THRESH(8)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .clr_count(clr_count),
    .locked(locked), .err(err), .lock_lost(lock_lost), .err_count(err_count));

  lfsr_checker #(.LENGTH(4), .COUNT_W(4), .WINDOW(64), .LOSS_THRESH(64)) dut_sat (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .clr_count(clr_count),
    .locked(locked_s), .err(err_s), .lock_lost(lock_lost_s), .err_count(err_count_s));

  int total = 0, passed = 0;
  bit pat[15] = '{1,1,1,1,0,1,0,1,1,0,0,1,0,0,0};
  int gi = 0;
  bit hist[$];
  bit m_locked, e_err, e_lost;
  int m_fill, m_wcnt, m_werr, m_count;
  int err_seen;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    hist.delete();
    m_locked = 0; m_fill = 0; m_wcnt = 0; m_werr = 0; m_count = 0;
    e_err = 0; e_lost = 0;
  endtask

  task automatic model_step(input bit d, input bit v, input bit clr);
    bit p;
    e_err = 0; e_lost = 0;
    if (v) begin
      if (!m_locked) begin
        hist.push_back(d);
        if (hist.size() > 4) void'(hist.pop_front());
        m_fill++;
        if (m_fill == 4) begin
          m_fill = 0;
          if (hist[0] | hist[1] | hist[2] | hist[3]) begin
            m_locked = 1; m_wcnt = 0; m_werr = 0;
          end
        end
      end else begin
        p = hist[0] ^ hist[3];
        hist.push_back(p);
        void'(hist.pop_front());
        m_wcnt++;
        if (d != p) begin
          e_err = 1; m_werr++;
          if (m_count < 65535) m_count++;
        end
        if (m_werr >= 8) begin
          m_locked = 0; e_lost = 1; m_fill = 0;
        end else if (m_wcnt == 64) begin
          m_wcnt = 0; m_werr = 0;
        end
      end
    end
    if (clr) m_count = 0;
  endtask

  task automatic step(input bit d, input bit v, input bit clr, input string tag);
    din = d; din_valid = v; clr_count = clr;
    @(posedge clk);
    model_step(d, v, clr);
    #1;
    if (err === 1'b1) err_seen++;
    chk({tag, "_locked"}, 32'(locked), 32'(m_locked));
    chk({tag, "_err"}, 32'(err), 32'(e_err));
    chk({tag, "_lock_lost"}, 32'(lock_lost), 32'(e_lost));
    chk({tag, "_err_count"}, 32'(err_count), 32'(m_count));
  endtask

  task automatic sbit(input bit inv, input bit clr, input string tag);
    step(pat[gi % 15] ^ inv, 1'b1, clr, tag);
    gi++;
  endtask

  task automatic pulse_reset();
    #2;
    rst = 1'b1;
    #1;
    chk("arst_locked", 32'(locked), 0);
    chk("arst_err_count", 32'(err_count), 0);
    chk("arst_locked_s", 32'(locked_s), 0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    bit found, v;
    rst = 1'b1; din = 1'b0; din_valid = 1'b0; clr_count = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_locked", 32'(locked), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_lock_lost", 32'(lock_lost), 0);
    chk("rst_err_count", 32'(err_count), 0);
    chk("rst_locked_s", 32'(locked_s), 0);
    chk("rst_err_count_s", 32'(err_count_s), 0);
    rst = 1'b0;

    // Clean stream: lock on the 4th bit, no errors.
    err_seen = 0;
    for (int i = 0; i < 30; i++) begin
      sbit(0, 0, "clean");
      if (i == 2) chk("pre_lock", 32'(locked), 0);
      if (i == 3) chk("lock_at_4", 32'(locked), 1);
    end
    chk("clean_no_err", 32'(err_seen), 0);
    chk("clean_count", 32'(err_count), 0);

    // One corrupted bit counts exactly once.
    err_seen = 0;
    for (int i = 0; i < 15; i++) begin
      sbit(i == 9, 0, "inv10");
      if (i == 9) chk("inv10_err", 32'(err), 1);
    end
    chk("inv10_pulses", 32'(err_seen), 1);
    chk("inv10_count", 32'(err_count), 1);
    chk("inv10_locked", 32'(locked), 1);

    // Move past the window boundary so the slip starts from a clean window.
    for (int i = 0; i < 30; i++) sbit(0, 0, "clean2");

    // Slip the stream by one bit: lock lost on the 8th mismatch.
    gi++;
    err_seen = 0;
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      sbit(0, 0, "slip");
      if (lock_lost === 1'b1) begin
        found = 1;
        chk("slip_err_pulses", 32'(err_seen), 8);
        chk("slip_err_same_cycle", 32'(err), 1);
        chk("slip_locked_fall", 32'(locked), 0);
      end
    end
    chk("slip_lock_lost_seen", 32'(found), 1);
    for (int i = 0; i < 4; i++) begin
      sbit(0, 0, "relock");
      if (i == 2) chk("relock_pre", 32'(locked), 0);
      if (i == 3) chk("relock_at_4", 32'(locked), 1);
    end

    // Valid gaps are bubbles, not errors.
    err_seen = 0;
    for (int i = 0; i < 60; i++) begin
      v = ($urandom_range(0, 3) != 0);
      if (v) sbit(0, 0, "gap");
      else step(1'($urandom_range(0, 1)), 1'b0, 1'b0, "gap_idle");
    end
    chk("gap_no_err", 32'(err_seen), 0);

    // Asynchronous reset mid-stream, then relock in 4 bits.
    pulse_reset();
    for (int i = 0; i < 4; i++) begin
      sbit(0, 0, "arst_relock");
      if (i == 2) chk("arst_pre", 32'(locked), 0);
      if (i == 3) chk("arst_lock", 32'(locked), 1);
    end

    // All-zero fill does not lock.
    pulse_reset();
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, "zeros");
    chk("zeros_no_lock", 32'(locked), 0);
    for (int i = 0; i < 4; i++) sbit(0, 0, "after_zeros");
    chk("after_zeros_lock", 32'(locked), 1);

    // Saturation on the 4-bit counter instance, then clear beats a same-cycle error.
    pulse_reset();
    for (int i = 0; i < 4; i++) sbit(0, 0, "sat_fill");
    chk("sat_locked", 32'(locked_s), 1);
    for (int i = 0; i < 20; i++) sbit(1, 0, "sat_inv");
    chk("sat_count", 32'(err_count_s), 15);
    chk("sat_still_locked", 32'(locked_s), 1);
    sbit(1, 1, "clr_err");
    chk("clr_count_s", 32'(err_count_s), 0);
    chk("clr_err_pulse_s", 32'(err_s), 1);

    // Random traffic against the model.
    for (int i = 0; i < 300; i++) begin
      v = ($urandom_range(0, 3) != 0);
      if (v) sbit(1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 29) == 0), "rand");
      else step(1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 29) == 0), "rand_idle");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/lfsr_checker.md
# lfsr_checker

Serial pseudo-random bit-sequence checker: the receive end of the LFSR pattern generator, used to verify a link or datapath carrying the generator's bit stream. It uses the same Fibonacci polynomial set as the generator. It self-synchronises by loading LENGTH received bits, then predicts and compares every following bit. It reports lock status, per-bit error pulses, a saturating error count, and loss of lock.

## Interface
- LENGTH, 4, register width and polynomial select; supported values are 2, 3, 4, 8 and 16.
- COUNT_W, 16, width of `err_count`.
- WINDOW, 64, number of compared bits per loss-of-lock evaluation window.
- LOSS_THRESH, 8, errors within one window that force loss of lock; must satisfy 1 ≤ LOSS_THRESH ≤ WINDOW.

- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- din  in  1  received stream bit. Its source is the generator's `out[0]`, one bit per generator step.
- din_valid  in  1  when high, `din` is sampled this cycle. When low, no state changes except `clr_count`.
- clr_count  in  1  synchronous clear of `err_count`.
- locked  out  1  high while in LOCKED.
- err  out  1  one-cycle pulse for each mismatched bit.
- lock_lost  out  1  one-cycle pulse on the LOCKED→SEARCH transition.
- err_count  out  COUNT_W  mismatches since reset or clear; saturates at all-ones.

## Operation
- History register `h[LENGTH-1:0]` is a shift register.
  - Each valid bit shifts in at the MSB and the oldest bit drops from the LSB: `h <= {bit, h[LENGTH-1:1]}`.
  - After LENGTH bits, `h` equals the generator's register state.
- Predicted bit `fb` (exclusive-OR of the listed `h` bits):
  - LENGTH 2: h0^h1.
  - LENGTH 3: h0^h2.
  - LENGTH 4: h0^h3.
  - LENGTH 8: h0^h2^h3^h4.
  - LENGTH 16: h0^h2^h3^h5.
- Unsupported LENGTH: the block stays in SEARCH permanently and all outputs stay at their reset values.
- State machine, two states:
  - SEARCH: every valid bit shifts `din` into `h` and increments `fill_cnt`.
    - On the LENGTH-th bit, examine the post-shift `h`.
    - Non-zero → LOCKED; `win_cnt` and `win_err` cleared.
    - All-zero (invalid state) → stay in SEARCH with `fill_cnt` = 0.
    - No comparisons and no `err` pulses occur in SEARCH.
  - LOCKED: every valid bit compares `din` with `fb`.
    - `h` shifts in `fb`, not `din`, so a single corrupted bit counts exactly once.
    - Mismatch: `err` pulses, `err_count` increments (saturating), `win_err` increments.
    - `win_cnt` counts compared bits from 0 to WINDOW-1.
    - If `win_err` including the current bit reaches LOSS_THRESH → SEARCH, `fill_cnt` = 0, `lock_lost` pulses.
    - Otherwise, on the bit with `win_cnt` = WINDOW-1, `win_cnt` and `win_err` clear to 0.
- `err_count` saturates at 2^COUNT_W − 1 and does not wrap.
- `clr_count` together with an error in the same cycle: the clear wins, so `err_count` = 0. `err` still pulses.
- `clr_count` does not affect the state, `h`, or the window counters.
- `din_valid` low: hold everything. A bubble in the stream is not an error.

## Timing
- Reset values: `locked` = 0, `err` = 0, `lock_lost` = 0, `err_count` = 0, state SEARCH, `h` = 0, all internal counters 0.
- Reset asserted mid-operation: all of the above values apply immediately (asynchronous); the block restarts in SEARCH.
- All outputs are registered.
- `locked` rises in the cycle after the edge that samples the LENGTH-th valid bit. The first compared bit is the (LENGTH+1)-th valid bit.
- `err` is high in the cycle after the edge that samples the bad bit. `err_count` updates in that same cycle.
- `lock_lost` and the fall of `locked` occur in the same cycle as the `err` pulse of the threshold-reaching bit.
- Throughput: one bit per clock; no back-pressure.

## Test plan
- LENGTH=4, reset, then 30 bits of the period-15 stream 1,1,1,1,0,1,0,1,1,0,0,1,0,0,0 with `din_valid` held high → `locked` rises the cycle after bit 4; `err` never pulses; `err_count` = 0.
- Same stream with bit 10 inverted → exactly one `err` pulse, one cycle after bit 10 is sampled; `err_count` = 1; `locked` stays high.
- Four zeros while in SEARCH, then the valid stream → no lock after the zeros; lock is acquired after the next four non-all-zero bits.
- WINDOW=64, LOSS_THRESH=8, stream slipped by one bit after lock → `lock_lost` pulses on the 8th mismatch, in the same cycle as the 8th `err` pulse, with `locked` falling in that cycle. The block then relocks after 4 more bits.
- COUNT_W=4, 20 inverted bits (LOSS_THRESH set to WINDOW) → `err_count` saturates at 15. Then `clr_count` together with an error → `err_count` = 0 and `err` pulses.
- Random `din_valid` gaps inside the clean stream → no errors. `rst` asserted mid-stream → all outputs 0 immediately and relock takes 4 bits.
